// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port, fixed-latency memory between the IF
//                (instruction fetch) and MEM (load/store) pipeline stages.
//                Requests are granted one at a time. The command is issued
//                with a one-cycle strobe, the response is timed by a latency
//                counter, and completion is signalled with a one-cycle ack.
//                The pipeline-wide stall is held until every request pending
//                in the current pipeline cycle has been served.
//  Options     : MEM_ARB_RR_EN - round-robin tie-break between IF and MEM.
//                When undefined, MEM always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2     // legal range 1..15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  // load/store port
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  // pipeline freeze
  output logic              stall_o,
  // memory side
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter preload: ISSUE plus MEM_LAT-1 WAIT decrements plus the capture
  // cycle put the sampling point exactly MEM_LAT cycles after ram_en_o.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic       owner_mem;    // 1 = current access belongs to MEM
  logic       if_done;      // IF already served in this pipeline cycle
  logic       mem_done;     // MEM already served in this pipeline cycle
  logic       if_elig;
  logic       mem_elig;
  logic       grant;
  logic       grant_mem;
  logic       in_resp;
  logic       capture;

`ifdef MEM_ARB_RR_EN
  logic       last_if;      // 1 = IF was granted most recently
`endif

  // Eligibility and tie-break; a served requester stays out until the
  // pipeline advances, so a held request is never served twice.
  always_comb begin
    if_elig  = if_req_i & ~if_done;
    mem_elig = mem_req_i & ~mem_done;
`ifdef MEM_ARB_RR_EN
    grant_mem = mem_elig & (~if_elig | last_if);
`else
    grant_mem = mem_elig;
`endif
    grant    = (state == IDLE) & (if_elig | mem_elig);
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = LAT_M1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch the winning command at grant; it stays on the ram_* pins until
  // the next grant, so requesters are free to change their inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_mem   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else if (grant) begin
      owner_mem   <= grant_mem;
      ram_we_o    <= grant_mem & mem_we_i;
      ram_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
      ram_wdata_o <= grant_mem ? mem_wdata_i : '0;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-grant pointer; resets to "IF last" so MEM wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_if <= 1'b1;
    end else if (grant) begin
      last_if <= ~grant_mem;
    end
  end
`endif

  // The read data is written straight into the owner's output register on
  // the capture edge so it is already valid during the ack cycle.
  assign capture = (state == WAIT) && (cnt == 4'd0);

  // Response data registers; a store leaves mem_rdata_o untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_data_o   <= '0;
      mem_rdata_o <= '0;
    end else if (capture) begin
      if (!owner_mem) begin
        if_data_o <= ram_rdata_i;
      end else if (!ram_we_o) begin
        mem_rdata_o <= ram_rdata_i;
      end
    end
  end

  // Acks are masked by reset so an interrupted access never completes.
  assign in_resp   = (state == RESP) & ~rst_i;
  assign if_ack_o  = in_resp & ~owner_mem;
  assign mem_ack_o = in_resp & owner_mem;
  assign ram_en_o  = (state == ISSUE);

  // Stall drops in the ack cycle of the last outstanding request.
  assign stall_o = (if_req_i  & ~(if_done  | if_ack_o))
                 | (mem_req_i & ~(mem_done | mem_ack_o));

  // Done flags: cleared whenever the pipeline advances, set at each ack.
  always_ff @(posedge clk_i) begin
    if (rst_i || !stall_o) begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
    end else begin
      if (if_ack_o) begin
        if_done <= 1'b1;
      end
      if (mem_ack_o) begin
        mem_done <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
